// File: rtl/sd_pic_writer.sv
// Frame-buffer-to-SD dump engine: each 12-bit pixel becomes three nibble-replicated bytes
// (B, G, R) streamed into consecutive 512-byte SD blocks; the last block is zero-padded.
module sd_pic_writer #(
  parameter int          PIXELS    = 60000,
  parameter logic [31:0] START_BLK = 32'h43C0,
  parameter int          FB_AW     = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [FB_AW-1:0] fb_addr_o,
  input  logic [11:0]      fb_data_i,
  input  logic             sd_ready_i,
  output logic             sd_wr_o,
  output logic [31:0]      sd_address_o,
  output logic [7:0]       sd_din_o,
  input  logic             sd_ready_for_next_byte_i
);
  localparam int            PW    = $clog2(PIXELS + 2);
  localparam logic [PW-1:0] PIX_N = PW'(PIXELS);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_RDY, SEND, PAD, BLK_END} state_t;

  state_t           state_q;
  logic [PW-1:0]    pix_cnt_q;
  logic [PW-1:0]    pix_inc_d;
  logic [31:0]      blk_q;
  logic [8:0]       byte_q;
  logic [1:0]       sub_q;
  logic [11:0]      pix_q;
  logic             busy_q, done_q, wr_q;
  logic [31:0]      addr_q;
  logic [7:0]       din_q;
  logic [FB_AW-1:0] fb_addr_q;

  assign pix_inc_d    = pix_cnt_q + PW'(1);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sd_wr_o      = wr_q;
  assign sd_address_o = addr_q;
  assign sd_din_o     = din_q;
  assign fb_addr_o    = fb_addr_q;

  function automatic logic [7:0] byte_of(input logic [11:0] p, input logic [1:0] s);
    case (s)
      2'd0:    return {p[3:0], p[3:0]};
      2'd1:    return {p[7:4], p[7:4]};
      default: return {p[11:8], p[11:8]};
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      blk_q     <= '0;
      byte_q    <= '0;
      sub_q     <= '0;
      pix_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      fb_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          pix_cnt_q <= '0;
          blk_q     <= START_BLK;
          byte_q    <= '0;
          sub_q     <= '0;
          fb_addr_q <= '0;
          busy_q    <= 1'b1;
          state_q   <= FETCH;
        end
        // fb_addr already holds pix_cnt here; only an empty picture ends in this state
        FETCH: if (pix_cnt_q == PIX_N) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          state_q <= LOAD;
        end
        LOAD: begin
          pix_q <= fb_data_i;
          sub_q <= '0;
          if (byte_q == 9'd0) begin
            state_q <= WAIT_RDY;
          end else begin
            din_q   <= byte_of(fb_data_i, 2'd0);
            state_q <= SEND;
          end
        end
        WAIT_RDY: if (sd_ready_i) begin
          wr_q    <= 1'b1;
          addr_q  <= blk_q;
          din_q   <= byte_of(pix_q, sub_q);
          state_q <= SEND;
        end
        SEND: if (sd_ready_for_next_byte_i) begin
          byte_q <= byte_q + 9'd1;
          if (sub_q == 2'd2) begin
            sub_q     <= '0;
            pix_cnt_q <= pix_inc_d;
            if (pix_inc_d != PIX_N) fb_addr_q <= FB_AW'(pix_inc_d);
          end else begin
            sub_q <= sub_q + 2'd1;
            din_q <= byte_of(pix_q, sub_q + 2'd1);
          end
          if (byte_q == 9'd511) begin
            wr_q    <= 1'b0;
            blk_q   <= blk_q + 32'd1;
            state_q <= BLK_END;
          end else if (sub_q == 2'd2) begin
            if (pix_inc_d == PIX_N) begin
              din_q   <= 8'h00;
              state_q <= PAD;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        PAD: if (sd_ready_for_next_byte_i) begin
          byte_q <= byte_q + 9'd1;
          if (byte_q == 9'd511) begin
            wr_q    <= 1'b0;
            blk_q   <= blk_q + 32'd1;
            state_q <= BLK_END;
          end
        end
        // sub==0 means the block boundary fell on a pixel boundary, so a fresh fetch is needed
        BLK_END: if (sd_ready_i) begin
          if (pix_cnt_q == PIX_N) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sub_q == 2'd0) begin
            state_q <= FETCH;
          end else begin
            state_q <= WAIT_RDY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_pic_writer.sv
// Bench for sd_pic_writer: a behavioural SD controller and picture RAM, with the expected
// byte stream built from the pixel array (B,G,R replicated nibbles, zero pad to 512).
module tb_sd_pic_writer;
  localparam int          P      = 171;
  localparam int          FB_AW  = 17;
  localparam logic [31:0] SB     = 32'h43C0;
  localparam int          BUDGET = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, sd_ready, pulse;
  logic [11:0]      fb_data;
  logic             busy, done, sd_wr;
  logic [FB_AW-1:0] fb_addr;
  logic [31:0]      sd_address;
  logic [7:0]       sd_din;

  logic             z_start, z_busy, z_done, z_wr;
  logic [FB_AW-1:0] z_fb_addr;
  logic [31:0]      z_addr;
  logic [7:0]       z_din;
  logic [11:0]      z_fb_data = 12'h000;
  logic             z_ready   = 1'b1;
  logic             z_pulse   = 1'b0;

  logic [11:0] mem [0:P-1];
  int checks = 0;
  int errors = 0;

  sd_pic_writer #(.PIXELS(P), .START_BLK(SB), .FB_AW(FB_AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .fb_addr_o(fb_addr), .fb_data_i(fb_data), .sd_ready_i(sd_ready), .sd_wr_o(sd_wr),
    .sd_address_o(sd_address), .sd_din_o(sd_din), .sd_ready_for_next_byte_i(pulse)
  );

  sd_pic_writer #(.PIXELS(0), .START_BLK(SB), .FB_AW(FB_AW)) dut_zero (
    .clk_i(clk), .rst_i(rst), .start_i(z_start), .busy_o(z_busy), .done_o(z_done),
    .fb_addr_o(z_fb_addr), .fb_data_i(z_fb_data), .sd_ready_i(z_ready), .sd_wr_o(z_wr),
    .sd_address_o(z_addr), .sd_din_o(z_din), .sd_ready_for_next_byte_i(z_pulse)
  );

  // synchronous-read picture RAM: data follows the address by one clock
  always @(posedge clk) begin
    if (fb_addr < FB_AW'(P)) fb_data <= mem[fb_addr[7:0]];
    else                     fb_data <= 12'h000;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_dump(input int gap_lo, input int gap_hi, input int ready_low,
                          input bit hold_start, input int abort_after);
    logic [7:0] exp_q[$];
    int idx, blk, in_blk, gap_cnt, prog_cnt, done_cnt, cyc, pad_seen, wr_bad, ready_cnt, phase;
    bit finished, aborting, aborted, rise_pending, first_prog;
    exp_q.delete();
    for (int p = 0; p < P; p++) begin
      exp_q.push_back({2{mem[p][3:0]}});
      exp_q.push_back({2{mem[p][7:4]}});
      exp_q.push_back({2{mem[p][11:8]}});
    end
    while (exp_q.size() % 512 != 0) exp_q.push_back(8'h00);
    idx = 0; blk = 0; in_blk = 0; gap_cnt = 0; prog_cnt = 0; done_cnt = 0; cyc = 0;
    pad_seen = 0; wr_bad = 0; phase = 0; ready_cnt = ready_low;
    finished = 0; aborting = 0; aborted = 0; rise_pending = 0; first_prog = 0;

    start = 1'b1; pulse = 1'b0; sd_ready = (ready_low == 0);
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    if (!hold_start) start = 1'b0;

    while (!finished && cyc < BUDGET) begin
      pulse = 1'b0;
      if (aborting) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sd_wr", sd_wr, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        aborted = 1; finished = 1;
      end else begin
        if (done) begin
          chk("busy_at_done", busy, 1'b0);
          done_cnt++;
          start = 1'b0;
          finished = 1;
        end
        if (ready_cnt > 0) begin
          ready_cnt--;
          if (ready_cnt == 0) begin sd_ready = 1'b1; rise_pending = 1; end
        end else if (rise_pending) begin
          chk("wr_cycle_after_ready", sd_wr, 1'b1);
          rise_pending = 0;
        end
        case (phase)
          0: begin
            if (sd_wr && !sd_ready) wr_bad++;
            else if (sd_wr && sd_ready) begin
              chk("blk_addr", sd_address, SB + 32'(blk));
              sd_ready = 1'b0; phase = 1; in_blk = 0; gap_cnt = 2;
            end
          end
          1: begin
            if (!sd_wr) wr_bad++;
            if (gap_cnt > 0) gap_cnt--;
            else begin
              pulse = 1'b1;
              if (idx < exp_q.size()) chk("byte", {idx[15:0], sd_din}, {idx[15:0], exp_q[idx]});
              if (idx >= 3 * P) pad_seen++;
              idx++; in_blk++;
              gap_cnt = $urandom_range(gap_hi, gap_lo) - 1;
              if (in_blk == 512) begin
                phase = 2; blk++; first_prog = 1;
                prog_cnt = $urandom_range(12, 3);
              end
              if (abort_after > 0 && idx == abort_after) aborting = 1;
            end
          end
          default: begin
            if (first_prog) begin chk("wr_low_blk_end", sd_wr, 1'b0); first_prog = 0; end
            if (prog_cnt > 0) prog_cnt--;
            else begin sd_ready = 1'b1; phase = 0; end
          end
        endcase
        @(negedge clk);
        cyc++;
      end
    end
    chk("dump_terminated", finished, 1'b1);
    if (!aborted) begin
      chk("byte_count", idx, (3 * P + 511) / 512 * 512);
      chk("blk_count", blk, (3 * P + 511) / 512);
      chk("pad_bytes", pad_seen, (512 - (3 * P) % 512) % 512);
      chk("wr_protocol", wr_bad, 0);
      repeat (30) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (busy) wr_bad++;
      end
      chk("done_count", done_cnt, 1);
      chk("no_restart", wr_bad, 0);
    end
    sd_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pulse = 1'b0; sd_ready = 1'b1; z_start = 1'b0;
    for (int i = 0; i < P; i++) mem[i] = 12'hABC;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sd_wr", sd_wr, 1'b0);
    chk("rst_sd_din", sd_din, 8'h00);
    chk("rst_sd_address", sd_address, 32'h0);
    chk("rst_fb_addr", fb_addr, '0);
    rst = 1'b0;
    @(negedge clk);

    // constant pixel ABC: CC BB AA repeating, split pixel over the block edge, pad
    run_dump(4, 7, 0, 1'b0, 0);

    for (int i = 0; i < P; i++) mem[i] = 12'($urandom);
    run_dump(4, 7, 0, 1'b0, 0);

    // controller busy for 50 cycles after start
    for (int i = 0; i < P; i++) mem[i] = 12'($urandom);
    run_dump(4, 6, 50, 1'b0, 0);

    // reset after byte 100 of block 0, then a full redump from pixel 0
    run_dump(4, 6, 0, 1'b0, 101);
    repeat (3) @(negedge clk);
    run_dump(4, 6, 0, 1'b0, 0);

    // start held high for the whole dump, byte pulses every 20 cycles
    for (int i = 0; i < P; i++) mem[i] = 12'($urandom);
    run_dump(20, 20, 0, 1'b1, 0);

    // empty picture: done two cycles after start, no block write
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    chk("zero_busy", z_busy, 1'b1);
    chk("zero_done_early", z_done, 1'b0);
    @(negedge clk);
    chk("zero_done", z_done, 1'b1);
    chk("zero_busy_end", z_busy, 1'b0);
    @(negedge clk);
    chk("zero_done_pulse", z_done, 1'b0);
    chk("zero_sd_wr", z_wr, 1'b0);
    chk("zero_fb_addr", z_fb_addr, '0);
    chk("zero_din", z_din, 8'h00);
    chk("zero_addr", z_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
